// File: rtl/sys_array_stream.sv
// Streaming weight-stationary systolic MAC array with internal input skew and output deskew.
// Optional build macro: SYS_ARRAY_SIGNED_EN selects two's-complement operands (default unsigned).
module sys_array_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(ARRAY_L)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]    w_data,
  input  logic                                  reload,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]    in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [0:ARRAY_W-1][ACC_WIDTH-1:0]     out_data,
  output logic                                  busy
);
  localparam int LAT = ARRAY_L + ARRAY_W;
  localparam int CW  = $clog2(LAT + 2);
  localparam int RCW = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [RCW-1:0]        r_row;
  logic                  r_w_ready;
  logic [DATA_WIDTH-1:0] r_w   [0:ARRAY_W-1][0:ARRAY_L-1];
  logic [DATA_WIDTH-1:0] r_x   [0:ARRAY_W-1][0:ARRAY_L-1];
  logic [ACC_WIDTH-1:0]  r_ps  [0:ARRAY_W-1][0:ARRAY_L-1];
  logic [ACC_WIDTH-1:0]  r_out [0:ARRAY_W-1];
  logic [LAT-1:0]        r_vld;
  logic                  r_out_valid;
  logic [CW-1:0]         r_cnt;

  logic                  w_adv;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [DATA_WIDTH-1:0] w_skew [0:ARRAY_L-1];
  logic [ACC_WIDTH-1:0]  w_ds   [0:ARRAY_W-1];

  // Product of one weight and one input element, extended to accumulator width.
  function automatic logic [ACC_WIDTH-1:0] mac_prod(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
`ifdef SYS_ARRAY_SIGNED_EN
    logic signed [2*DATA_WIDTH-1:0] v_p;
    v_p = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    return ACC_WIDTH'(v_p);
`else
    logic [2*DATA_WIDTH-1:0] v_p;
    v_p = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    return ACC_WIDTH'(v_p);
`endif
  endfunction

  // A stalled output beat freezes every pipeline stage so wavefronts stay aligned.
  assign w_adv     = !(r_out_valid && !out_ready);
  assign in_ready  = (r_state == S_RUN) && w_adv;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_out_valid && out_ready;
  assign w_ready   = r_w_ready;
  assign out_valid = r_out_valid;
  assign busy      = (r_cnt != '0);

  // Control FSM: row-by-row weight load, streaming, and drain before reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_row     <= '0;
      r_w_ready <= 1'b1;
      for (int i = 0; i < ARRAY_W; i++) begin
        for (int j = 0; j < ARRAY_L; j++) begin
          r_w[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_valid) begin
            for (int j = 0; j < ARRAY_L; j++) begin
              r_w[r_row][j] <= w_data[j];
            end
            if (r_row == RCW'(ARRAY_W - 1)) begin
              r_row     <= '0;
              r_state   <= S_RUN;
              r_w_ready <= 1'b0;
            end else begin
              r_row <= r_row + RCW'(1);
            end
          end
        end
        S_RUN: begin
          if (reload) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state   <= S_LOAD;
            r_w_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_LOAD;
          r_row     <= '0;
          r_w_ready <= 1'b1;
        end
      endcase
    end
  end

  // In-flight vector count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Input skew: column j reaches row 0 j cycles after column 0.
  for (genvar j = 0; j < ARRAY_L; j++) begin : g_skew
    if (j == 0) begin : g_direct
      assign w_skew[j] = in_data[j];
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] r_sk [0:j-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < j; k++) begin
            r_sk[k] <= '0;
          end
        end else if (w_adv) begin
          r_sk[0] <= in_data[j];
          for (int k = 1; k < j; k++) begin
            r_sk[k] <= r_sk[k-1];
          end
        end
      end
      assign w_skew[j] = r_sk[j-1];
    end
  end

  // MAC grid: inputs move down rows, partial sums move across columns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < ARRAY_W; i++) begin
        r_out[i] <= '0;
        for (int j = 0; j < ARRAY_L; j++) begin
          r_x[i][j]  <= '0;
          r_ps[i][j] <= '0;
        end
      end
    end else if (w_adv) begin
      r_vld       <= {r_vld[LAT-2:0], w_in_hs};
      r_out_valid <= r_vld[LAT-1];
      for (int j = 0; j < ARRAY_L; j++) begin
        r_x[0][j] <= w_skew[j];
      end
      for (int i = 1; i < ARRAY_W; i++) begin
        for (int j = 0; j < ARRAY_L; j++) begin
          r_x[i][j] <= r_x[i-1][j];
        end
      end
      for (int i = 0; i < ARRAY_W; i++) begin
        r_ps[i][0] <= mac_prod(r_w[i][0], r_x[i][0]);
        for (int j = 1; j < ARRAY_L; j++) begin
          r_ps[i][j] <= r_ps[i][j-1] + mac_prod(r_w[i][j], r_x[i][j]);
        end
        r_out[i] <= w_ds[i];
      end
    end
  end

  // Output deskew: row i finishes i cycles after row 0, so earlier rows wait longer.
  for (genvar i = 0; i < ARRAY_W; i++) begin : g_deskew
    if (i == ARRAY_W - 1) begin : g_direct
      assign w_ds[i] = r_ps[i][ARRAY_L-1];
    end else begin : g_chain
      logic [ACC_WIDTH-1:0] r_ds [0:ARRAY_W-2-i];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k <= ARRAY_W - 2 - i; k++) begin
            r_ds[k] <= '0;
          end
        end else if (w_adv) begin
          r_ds[0] <= r_ps[i][ARRAY_L-1];
          for (int k = 1; k <= ARRAY_W - 2 - i; k++) begin
            r_ds[k] <= r_ds[k-1];
          end
        end
      end
      assign w_ds[i] = r_ds[ARRAY_W-2-i];
    end
    assign out_data[i] = r_out[i];
  end

endmodule
